uart_stream_bridge: RTL
=======================

Name: uart_stream_bridge

Overview:
Buffered, parametrised bridge between the existing uart core's byte handshake (rdy/rdy_clr receive, wr_en/tx_busy transmit) and a valid/ready stream interface. It replaces ad-hoc single-byte polling with independent RX and TX FIFOs, occupancy reporting and sticky overflow detection. It sits between a uart instance and any on-chip consumer: a debug or host-link engine, or a UART peripheral front end in keynsham_soc.

Parameters:
DATA_WIDTH, 8, character width; must match the uart core's din/dout width.
RX_DEPTH, 16, RX FIFO entries; power of two, at least 2.
TX_DEPTH, 16, TX FIFO entries; power of two, at least 2.
LVL_W, $clog2(max(RX_DEPTH,TX_DEPTH))+1, width of the level outputs (derived; do not override).

Ports:
clk  in  1  single system clock (50 MHz in the SoC); all logic on its rising edge.
rst  in  1  asynchronous, active-high reset.
uart_rdy  in  1  uart core: received character available.
uart_dout  in  DATA_WIDTH  uart core: received character.
uart_rdy_clr  out  1  uart core: acknowledge/clear received character.
uart_tx_busy  in  1  uart core: transmitter busy.
uart_wr_en  out  1  uart core: start transmit.
uart_din  out  DATA_WIDTH  uart core: character to transmit.
rx_data  out  DATA_WIDTH  stream out: FIFO head character.
rx_valid  out  1  stream out: RX FIFO not empty.
rx_ready  in  1  stream out: consumer accepts head.
tx_data  in  DATA_WIDTH  stream in: character to send.
tx_valid  in  1  stream in: character offered.
tx_ready  out  1  stream in: TX FIFO not full.
rx_level  out  LVL_W  RX FIFO occupancy.
tx_level  out  LVL_W  TX FIFO occupancy.
rx_overflow  out  1  sticky: a received character was dropped.
ovf_clr  in  1  clears rx_overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst. Every flop resets on posedge rst, independent of clk.
- Reset values: uart_rdy_clr=0, uart_wr_en=0, uart_din=0, rx_valid=0, tx_ready=1, rx_level=0, tx_level=0, rx_overflow=0. Both FIFOs empty. TX FSM in TX_IDLE.
- Reset mid-operation: a character in flight inside the uart core is not aborted. A later uart_rdy is handled normally.
- RX capture:
  - Condition: uart_rdy && !uart_rdy_clr.
  - Always drive uart_rdy_clr=1 for exactly the next cycle (registered); the character is acknowledged whether or not it is kept.
  - RX FIFO not full: push uart_dout.
  - RX FIFO full: discard the character and set rx_overflow.
  - Back-to-back captures are impossible by construction, because clr is high in between.
- RX stream:
  - First-word-fall-through: rx_data is valid whenever rx_valid=1.
  - Pop on rx_valid && rx_ready.
  - Capture latency: a pushed character gives rx_valid=1 on the cycle after the push edge.
- Simultaneous RX push and pop:
  - Level unchanged.
  - On a full FIFO, the pop frees space first, so the push succeeds and no overflow is flagged.
- rx_overflow:
  - Set has priority over ovf_clr in the same cycle.
  - Otherwise ovf_clr clears it on the next edge.
- TX stream: push on tx_valid && tx_ready. tx_ready = !full (combinational from registered level).
- TX FSM (2-bit):
  - TX_IDLE: if the FIFO is not empty and uart_tx_busy=0, load uart_din from the head, pop the head, assert uart_wr_en, go to TX_START.
  - TX_START: uart_wr_en=1 (held one cycle only; deassert on exit). If uart_tx_busy=1, go to TX_IDLE. Otherwise go to TX_WAIT.
  - TX_WAIT: uart_wr_en=0. Stay until uart_tx_busy=1, then go to TX_IDLE. This guarantees busy is observed before the next issue, so no character is lost to the core's start latency.
  - uart_din holds its value until the next load.
- Simultaneous TX push and pop: level unchanged. Push into the slot freed in the same cycle is allowed only if the FIFO was not full at the start of the cycle (tx_ready is not speculative).
- Levels:
  - Occupancy counters range 0..DEPTH.
  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
  - Full = (level==DEPTH). Empty = (level==0).

Decomposition:
- Shared header uart_bridge_defs.vh: TX FSM state encodings (TX_IDLE=2'd0, TX_START=2'd1, TX_WAIT=2'd2) and default depth constants.
- One sub-module, sync_fifo (parameters WIDTH and DEPTH; first-word-fall-through; push/pop/full/empty/level), instantiated twice.
- Capture logic, overflow flag and TX FSM stay in uart_stream_bridge.

Test Plan:
- Reset: assert rst asynchronously between clk edges with both FIFOs partly full -> on that same instant all outputs take their reset values; rx_level=0, tx_level=0, tx_ready=1.
- RX burst: uart_rdy with dout 0x41, 0x42, 0x43, each held until rdy_clr, rx_ready=0 -> rx_level=3, one-cycle rdy_clr per character, rx_data=0x41. Then rx_ready=1 for 3 cycles -> 0x41, 0x42, 0x43 delivered in order, rx_valid=0.
- RX overflow: RX_DEPTH=16, inject 17 characters 0x00..0x10 with rx_ready=0 -> rx_level=16, rx_overflow=1, the 17th still acknowledged, FIFO holds 0x00..0x0F. ovf_clr pulse -> rx_overflow=0. Overflow event coincident with ovf_clr -> rx_overflow stays 1.
- Full-FIFO push+pop: RX FIFO full, rx_ready=1 in the capture cycle of 0x55 -> no overflow, level stays 16, 0x55 is the last entry.
- TX pacing: queue 0x48, 0x69; uart_tx_busy model rises 2 cycles after wr_en and stays high 10 cycles -> exactly two one-cycle wr_en pulses, second only after busy falls, uart_din=0x48 then 0x69.
- TX full: push 16 characters while uart_tx_busy=1 -> tx_ready=0 at tx_level=16, a 17th tx_valid not accepted. Release busy -> drains in FIFO order.

Source files
------------

// File: rtl/uart_stream_bridge_pkg.sv
// Shared definitions for the uart <-> valid/ready stream bridge:
// default sizes, TX sequencer state encodings and a sizing helper.
package uart_stream_bridge_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_RX_DEPTH   = 16;
  localparam int unsigned DEF_TX_DEPTH   = 16;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_WAIT  = 2'd2
  } tx_state_e;

  function automatic int unsigned max_depth(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_stream_bridge_if.sv
// Valid/ready stream pair between the bridge (slave) and an on-chip consumer (master).
interface uart_stream_bridge_if
  import uart_stream_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy counter.
// A push while full is accepted only if a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    level_q;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rptr_q];
  assign level   = LVL_W'(level_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop_ok) rptr_q <= rptr_q + AW'(1);
      if (push_ok && !pop_ok)      level_q <= level_q + LW'(1);
      else if (pop_ok && !push_ok) level_q <= level_q - LW'(1);
    end
  end

endmodule

// File: rtl/uart_stream_bridge.sv
// Buffered bridge between the uart core byte handshake and a valid/ready stream:
// RX capture with sticky overflow, TX sequencer that waits for busy before re-issuing.
module uart_stream_bridge
  import uart_stream_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned RX_DEPTH   = DEF_RX_DEPTH,
  parameter int unsigned TX_DEPTH   = DEF_TX_DEPTH,
  parameter int unsigned LVL_W      = $clog2(max_depth(RX_DEPTH, TX_DEPTH)) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rdy,
  input  logic [DATA_WIDTH-1:0] uart_dout,
  output logic                  uart_rdy_clr,
  input  logic                  uart_tx_busy,
  output logic                  uart_wr_en,
  output logic [DATA_WIDTH-1:0] uart_din,
  uart_stream_bridge_if.slave   strm,
  output logic [LVL_W-1:0]      rx_level,
  output logic [LVL_W-1:0]      tx_level,
  output logic                  rx_overflow,
  input  logic                  ovf_clr
);
  logic                  capture, rx_pop, rx_full, rx_empty;
  logic                  tx_push, tx_issue, tx_full, tx_empty;
  logic [DATA_WIDTH-1:0] tx_head;
  tx_state_e             tx_state_q;

  // clr is high the cycle after a capture, so the same character is never taken twice
  assign capture = uart_rdy && !uart_rdy_clr;
  assign rx_pop  = strm.rx_valid && strm.rx_ready;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RX_DEPTH),
    .LVL_W (LVL_W)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .wdata (uart_dout),
    .pop   (rx_pop),
    .rdata (strm.rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  assign strm.rx_valid = !rx_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_rdy_clr <= 1'b0;
      rx_overflow  <= 1'b0;
    end else begin
      uart_rdy_clr <= capture;
      if (capture && rx_full && !rx_pop) rx_overflow <= 1'b1;
      else if (ovf_clr)                  rx_overflow <= 1'b0;
    end
  end

  assign strm.tx_ready = !tx_full;
  assign tx_push       = strm.tx_valid && strm.tx_ready;
  assign tx_issue      = (tx_state_q == TX_IDLE) && !tx_empty && !uart_tx_busy;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (TX_DEPTH),
    .LVL_W (LVL_W)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (strm.tx_data),
    .pop   (tx_issue),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  // WAIT holds off the next issue until the core has shown busy for this character
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      uart_wr_en <= 1'b0;
      uart_din   <= '0;
    end else begin
      unique case (tx_state_q)
        TX_IDLE: begin
          if (tx_issue) begin
            uart_din   <= tx_head;
            uart_wr_en <= 1'b1;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          uart_wr_en <= 1'b0;
          tx_state_q <= uart_tx_busy ? TX_IDLE : TX_WAIT;
        end
        TX_WAIT: begin
          uart_wr_en <= 1'b0;
          if (uart_tx_busy) tx_state_q <= TX_IDLE;
        end
        default: begin
          uart_wr_en <= 1'b0;
          tx_state_q <= TX_IDLE;
        end
      endcase
    end
  end

endmodule
